// File: rtl/matproc_pkg.sv
`default_nettype none
// ============================================================================
// Module      : matproc_pkg
// Description : Shared definitions for the matrix processor arithmetic units
//               (sequential multiplier and shift-subtract divider).
//               - mul_state_t : multiplier sequencing states
//               - abs_mag()   : two's complement magnitude helper
//               - DEF_WIDTH / DEF_FRAC : default operand format
// Revision    : 1.0 - initial release
// ============================================================================
package matproc_pkg;

    localparam int DEF_WIDTH = 32;
    localparam int DEF_FRAC  = 0;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        MULTIPLY  = 2'd1,
        NORMALIZE = 2'd2
    } mul_state_t;

    // Magnitude of a sign-extended operand (operands up to 64 bits). The
    // result is unsigned, so the most negative value maps to 2^(w-1) rather
    // than wrapping back onto itself.
    function automatic logic [63:0] abs_mag(input logic signed [63:0] v);
        return v[63] ? 64'(-v) : 64'(v);
    endfunction

endpackage : matproc_pkg
`default_nettype wire

// File: rtl/fixed_normalize.sv
`default_nettype none
// ============================================================================
// Module      : fixed_normalize
// Description : Combinational round / shift / saturate / negate stage that
//               turns an unsigned double-width magnitude plus a sign into a
//               signed WIDTH-bit fixed-point result.
// Ports       : acc      in  2*WIDTH  unsigned product magnitude
//               sign     in  1        result sign (1 = negative)
//               product  out WIDTH    signed, rounded, saturated result
//               overflow out 1        1 when the result was saturated
// Revision    : 1.0 - initial release
// ============================================================================
module fixed_normalize #(
    parameter int WIDTH = 32,
    parameter int FRAC  = 0
) (
    input  logic [2*WIDTH-1:0] acc,
    input  logic               sign,
    output logic [WIDTH-1:0]   product,
    output logic               overflow
);

    localparam int ACCW = 2 * WIDTH;
    // Largest representable positive magnitude, and the negative one which
    // is one larger.
    localparam logic [ACCW-1:0] POS_MAX = (ACCW'(1) << (WIDTH - 1)) - ACCW'(1);
    localparam logic [ACCW-1:0] NEG_MAX = ACCW'(1) << (WIDTH - 1);

    logic [ACCW-1:0]  mag;
    logic [WIDTH-1:0] mag_lo;

    // Rounding is applied to the magnitude, so ties go away from zero for
    // both signs. The accumulator never exceeds 2^(2W-2), so adding the
    // half-LSB cannot carry out of ACCW bits.
    if (FRAC > 0) begin : g_round
        localparam logic [ACCW-1:0] HALF = ACCW'(1) << (FRAC - 1);
        assign mag = (acc + HALF) >> FRAC;
    end else begin : g_no_round
        assign mag = acc;
    end

    assign mag_lo = mag[WIDTH-1:0];

    always_comb begin
        product  = sign ? -mag_lo : mag_lo;
        overflow = 1'b0;
        if (!sign && (mag > POS_MAX)) begin
            product  = POS_MAX[WIDTH-1:0];
            overflow = 1'b1;
        end else if (sign && (mag > NEG_MAX)) begin
            product  = NEG_MAX[WIDTH-1:0];
            overflow = 1'b1;
        end
    end

endmodule : fixed_normalize
`default_nettype wire

// File: rtl/seq_multiplier.sv
`default_nettype none
// ============================================================================
// Module      : seq_multiplier
// Description : Sequential signed fixed-point shift-and-add multiplier.
//               A start pulse samples the operands; WIDTH+1 cycles later a
//               rounded, saturated result is registered and finished rises.
// Ports       : clk          in  1      clock, rising edge
//               rst_n        in  1      synchronous active-low reset
//               start        in  1      launch / restart, samples operands
//               multiplicand in  WIDTH  signed operand A
//               multiplier   in  WIDTH  signed operand B
//               product      out WIDTH  registered signed result
//               overflow     out 1      registered, last result saturated
//               finished     out 1      high while idle
// Revision    : 1.0 - initial release
// ============================================================================
module seq_multiplier
    import matproc_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,   // 2..64
    parameter int FRAC  = DEF_FRAC     // 0..WIDTH-1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] multiplicand,
    input  logic [WIDTH-1:0] multiplier,
    output logic [WIDTH-1:0] product,
    output logic             overflow,
    output logic             finished
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    mul_state_t         state;
    logic [CW-1:0]      count;
    logic [2*WIDTH-1:0] acc;
    logic [WIDTH-1:0]   mag_a;
    logic [WIDTH-1:0]   mag_b;
    logic               sign;

    logic signed [63:0] ext_a;
    logic signed [63:0] ext_b;
    logic [WIDTH-1:0]   norm_product;
    logic               norm_overflow;

    assign ext_a = 64'($signed(multiplicand));
    assign ext_b = 64'($signed(multiplier));

    fixed_normalize #(
        .WIDTH (WIDTH),
        .FRAC  (FRAC)
    ) u_normalize (
        .acc      (acc),
        .sign     (sign),
        .product  (norm_product),
        .overflow (norm_overflow)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            finished <= 1'b1;
            product  <= '0;
            overflow <= 1'b0;
            count    <= '0;
            acc      <= '0;
            mag_a    <= '0;
            mag_b    <= '0;
            sign     <= 1'b0;
        end else if (start) begin
            // Accepted in every state; an operation in flight is dropped
            // without touching product/overflow.
            sign     <= multiplicand[WIDTH-1] ^ multiplier[WIDTH-1];
            mag_a    <= WIDTH'(abs_mag(ext_a));
            mag_b    <= WIDTH'(abs_mag(ext_b));
            acc      <= '0;
            count    <= '0;
            state    <= MULTIPLY;
            finished <= 1'b0;
        end else begin
            case (state)
                MULTIPLY: begin
                    if (mag_b[count]) begin
                        acc <= acc + ({{WIDTH{1'b0}}, mag_a} << count);
                    end
                    count <= count + 1'b1;
                    if (count == LAST) begin
                        state <= NORMALIZE;
                    end
                end
                NORMALIZE: begin
                    product  <= norm_product;
                    overflow <= norm_overflow;
                    state    <= IDLE;
                    finished <= 1'b1;
                end
                default: begin
                    state    <= IDLE;
                    finished <= 1'b1;
                end
            endcase
        end
    end

endmodule : seq_multiplier
`default_nettype wire
